// File: rtl/conv1d_multi_filter_pe.sv
// conv1d_multi_filter_pe
// Multi-filter 1-D convolution processing element. Filters and one ifmap row
// are held in local scratchpads; the filters then slide across the row with a
// programmable stride, one MAC per cycle. Each (window, filter) result leaves
// through a valid/ready port with back-pressure.
// Optional build macro CONV_PE_SATURATE_EN: clamp results that overflow OUT_W
// to all ones instead of keeping the low OUT_W bits.
module conv1d_multi_filter_pe #(
    parameter int IF_W        = 8,
    parameter int FILT_W      = 8,
    parameter int OUT_W       = 24,
    parameter int IF_DEPTH    = 16,
    parameter int FILTER_SIZE = 4,
    parameter int NUM_FILTERS = 2,
    parameter int STRIDE_W    = 2,
    localparam int FI_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                reload_filters,
    input  logic [STRIDE_W-1:0] stride,
    input  logic                flt_valid,
    output logic                flt_ready,
    input  logic [FILT_W-1:0]   flt_data,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [IF_W-1:0]     if_data,
    input  logic                if_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [FI_W-1:0]     out_filter,
    output logic                busy,
    output logic                done
);

    localparam int AW     = (IF_DEPTH > 1) ? $clog2(IF_DEPTH) : 1;
    localparam int LEN_W  = $clog2(IF_DEPTH + 1);
    localparam int NFW    = NUM_FILTERS * FILTER_SIZE;
    localparam int FAW    = (NFW > 1) ? $clog2(NFW) : 1;
    localparam int TW     = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int PROD_W = IF_W + FILT_W;
    localparam int ACC_W  = PROD_W + $clog2(FILTER_SIZE);
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    // Wide enough to hold window base + stride + FILTER_SIZE without overflow.
    localparam int CW     = $clog2(IF_DEPTH + FILTER_SIZE + (1 << STRIDE_W)) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FILT,
        S_LOAD_IF,
        S_COMPUTE,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Job configuration and load counters
    logic [STRIDE_W-1:0] r_stride;
    logic [FAW-1:0]      r_fcnt;
    logic [LEN_W-1:0]    r_len;

    // Issue-stage counters: window base, filter, tap
    logic [AW-1:0]  r_win;
    logic [TW-1:0]  r_tap;
    logic [FI_W-1:0] r_filt;
    logic [FAW-1:0] r_flt_addr;
    logic           r_issuing;

    // Scratchpads
    logic [IF_W-1:0]   r_if_mem  [IF_DEPTH];
    logic [FILT_W-1:0] r_flt_mem [NFW];

    // Operand stage
    logic [IF_W-1:0]   r_if_op;
    logic [FILT_W-1:0] r_flt_op;
    logic              r_v1, r_first1, r_last1;
    logic [FI_W-1:0]   r_f1;

    // Product stage
    logic [PROD_W-1:0] r_prod;
    logic              r_v2, r_first2, r_last2;
    logic [FI_W-1:0]   r_f2;

    // Accumulator and output register
    logic [ACC_W-1:0]  r_acc;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic [FI_W-1:0]   r_out_filter;

    logic                w_stall;
    logic                w_flt_fire;
    logic                w_if_fire;
    logic                w_if_end;
    logic [LEN_W-1:0]    w_len_inc;
    logic                w_issue;
    logic [AW-1:0]       w_if_addr;
    logic                w_tap_last;
    logic                w_filt_last;
    logic [CW-1:0]       w_win_cand;
    logic                w_win_ok;
    logic [STRIDE_W-1:0] w_stride_eff;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [OUT_W-1:0]    w_result;

    // A result waiting on a stalled consumer freezes the whole pipeline.
    assign w_stall      = r_out_valid & ~out_ready;
    assign w_flt_fire   = (r_state == S_LOAD_FILT) & flt_valid;
    assign w_if_fire    = (r_state == S_LOAD_IF) & if_valid;
    assign w_if_end     = w_if_fire & (if_last | (r_len == LEN_W'(IF_DEPTH - 1)));
    assign w_len_inc    = r_len + LEN_W'(1);
    assign w_issue      = (r_state == S_COMPUTE) & r_issuing & ~w_stall;
    assign w_if_addr    = r_win + AW'(r_tap);
    assign w_tap_last   = (r_tap == TW'(FILTER_SIZE - 1));
    assign w_filt_last  = (r_filt == FI_W'(NUM_FILTERS - 1));
    assign w_win_cand   = CW'(r_win) + CW'(r_stride);
    assign w_win_ok     = (w_win_cand + CW'(FILTER_SIZE)) <= CW'(r_len);
    assign w_stride_eff = (stride == '0) ? STRIDE_W'(1) : stride;
    assign w_acc_sum    = (r_first2 ? '0 : r_acc) + ACC_W'(r_prod);

`ifdef CONV_PE_SATURATE_EN
    assign w_result = (EXT_W'(w_acc_sum) > EXT_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}}
                                                                  : OUT_W'(w_acc_sum);
`else
    assign w_result = OUT_W'(w_acc_sum);
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_filter = r_out_filter;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic and per-state handshake/status outputs
    always_comb begin
        w_state_next = r_state;
        flt_ready    = 1'b0;
        if_ready     = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = reload_filters ? S_LOAD_FILT : S_LOAD_IF;
            end
            S_LOAD_FILT: begin
                flt_ready = 1'b1;
                if (w_flt_fire && (r_fcnt == FAW'(NFW - 1))) w_state_next = S_LOAD_IF;
            end
            S_LOAD_IF: begin
                if_ready = 1'b1;
                if (w_if_end)
                    w_state_next = (CW'(w_len_inc) < CW'(FILTER_SIZE)) ? S_FINISH : S_COMPUTE;
            end
            S_COMPUTE: begin
                // Leave only once nothing is issuing, in flight, or awaiting transfer.
                if (!r_issuing && !r_v1 && !r_v2 && (!r_out_valid || out_ready))
                    w_state_next = S_FINISH;
            end
            S_FINISH: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Job configuration, load counters and issue-stage address generation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stride   <= '0;
            r_fcnt     <= '0;
            r_len      <= '0;
            r_win      <= '0;
            r_tap      <= '0;
            r_filt     <= '0;
            r_flt_addr <= '0;
            r_issuing  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_stride <= w_stride_eff;
                r_len    <= '0;
                r_fcnt   <= '0;
            end
            if (w_flt_fire)
                r_fcnt <= (r_fcnt == FAW'(NFW - 1)) ? '0 : r_fcnt + FAW'(1);
            if (w_if_fire)
                r_len <= w_len_inc;
            if (r_state == S_LOAD_IF && w_state_next == S_COMPUTE) begin
                r_issuing  <= 1'b1;
                r_win      <= '0;
                r_tap      <= '0;
                r_filt     <= '0;
                r_flt_addr <= '0;
            end
            if (w_issue) begin
                if (w_tap_last) begin
                    r_tap <= '0;
                    if (w_filt_last) begin
                        r_filt     <= '0;
                        r_flt_addr <= '0;
                        // Only step to windows that fit entirely inside the row.
                        if (w_win_ok) r_win <= AW'(w_win_cand);
                        else          r_issuing <= 1'b0;
                    end else begin
                        r_filt     <= r_filt + FI_W'(1);
                        r_flt_addr <= r_flt_addr + FAW'(1);
                    end
                end else begin
                    r_tap      <= r_tap + TW'(1);
                    r_flt_addr <= r_flt_addr + FAW'(1);
                end
            end
        end
    end

    // Scratchpad writes during the load phases
    always_ff @(posedge clk) begin
        if (w_flt_fire) r_flt_mem[r_fcnt] <= flt_data;
        if (w_if_fire)  r_if_mem[r_len[AW-1:0]] <= if_data;
    end

    // Registered scratchpad reads feeding the operand stage
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_if_op  <= r_if_mem[w_if_addr];
            r_flt_op <= r_flt_mem[r_flt_addr];
        end
    end

    // Tag pipeline, multiplier, accumulator and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1         <= 1'b0;
            r_first1     <= 1'b0;
            r_last1      <= 1'b0;
            r_f1         <= '0;
            r_v2         <= 1'b0;
            r_first2     <= 1'b0;
            r_last2      <= 1'b0;
            r_f2         <= '0;
            r_prod       <= '0;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_filter <= '0;
        end else begin
            if (!w_stall) begin
                r_v1     <= w_issue;
                r_first1 <= (r_tap == '0);
                r_last1  <= w_tap_last;
                r_f1     <= r_filt;
                r_v2     <= r_v1;
                r_first2 <= r_first1;
                r_last2  <= r_last1;
                r_f2     <= r_f1;
                r_prod   <= PROD_W'(r_if_op) * PROD_W'(r_flt_op);
                if (r_v2) r_acc <= w_acc_sum;
            end
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
            // A new result may load on the same edge the previous one transfers.
            if (!w_stall && r_v2 && r_last2) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_result;
                r_out_filter <= r_f2;
            end
        end
    end

endmodule

// File: doc/conv1d_multi_filter_pe.md
Name: conv1d_multi_filter_pe

Overview:
Next-generation convolution processing element. Holds NUM_FILTERS filters and one ifmap row in internal scratchpads, then slides the filters across the row with a programmable stride. It computes one MAC per cycle and streams one result per (window, filter) pair through a valid/ready output port. It replaces the single-filter datapath, adding multi-filter reuse, an output handshake with back-pressure, and a short-row guard.

Parameters:
IF_W, 8, ifmap element width (unsigned)
FILT_W, 8, filter element width (unsigned)
OUT_W, 24, output result width
IF_DEPTH, 16, ifmap scratchpad rows (max row length)
FILTER_SIZE, 4, taps per filter
NUM_FILTERS, 2, filters held concurrently
STRIDE_W, 2, stride input width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begin a job (sampled in IDLE only)
reload_filters  in  1  sampled with start; 1 = load new filters before the row
stride  in  STRIDE_W  window step, sampled at start; 0 is treated as 1
flt_valid  in  1  filter word valid
flt_ready  out  1  filter word accepted when flt_valid&flt_ready
flt_data  in  FILT_W  filter words, filter 0 tap 0 first, tap-major within each filter
if_valid  in  1  ifmap word valid
if_ready  out  1  ifmap handshake
if_data  in  IF_W  ifmap word
if_last  in  1  marks last word of the row
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  OUT_W  result
out_filter  out  max(1,clog2(NUM_FILTERS))  filter index of result
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when job completes

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters, accumulator and row length cleared. Scratchpad contents are don't-care. Reset mid-job aborts immediately with no further outputs.
- States: IDLE -> LOAD_FILT (only if reload_filters) -> LOAD_IF -> COMPUTE -> FINISH -> IDLE.
- IDLE: start=1 latches stride and reload_filters. start is ignored while busy.
- LOAD_FILT:
  - flt_ready=1; accepts exactly NUM_FILTERS*FILTER_SIZE words, one per handshake.
  - Moves to LOAD_IF the cycle after the last word.
  - Filters persist across jobs when reload_filters=0.
- LOAD_IF:
  - if_ready=1; writes words to address 0 upward.
  - Ends on the handshake with if_last=1, or on the IF_DEPTH-th word (implicit last).
  - len = words written.
- COMPUTE:
  - Window base p = 0, s, 2s, ... while p+FILTER_SIZE <= len.
  - For each p, filters f = 0..NUM_FILTERS-1 in order.
  - Each (p,f) takes FILTER_SIZE tap cycles: acc += if[p+k]*flt[f][k].
  - Pipeline: scratchpad read -> operand regs -> product reg -> accumulator.
  - First out_valid appears FILTER_SIZE+2 cycles after COMPUTE entry, with no stalls.
  - Under continuous out_ready, results are spaced FILTER_SIZE cycles apart.
- Arithmetic:
  - Unsigned. Product is IF_W+FILT_W bits.
  - Accumulator is IF_W+FILT_W+clog2(FILTER_SIZE) bits, cleared at each (p,f) start.
  - out_data = low OUT_W bits of the accumulator (wrap).
- Output handshake:
  - out_data and out_filter are held stable while out_valid=1 and out_ready=0.
  - The pipeline stalls: no tap advance, no accumulator update.
  - Result transfers on out_valid&out_ready.
  - A new result may present on the cycle after the transfer.
- Short row: len < FILTER_SIZE gives zero results; COMPUTE is skipped and the FSM goes straight to FINISH.
- FINISH: done=1 for one cycle, after the last result transfers, then IDLE.
- Result count = (floor((len-FILTER_SIZE)/s)+1)*NUM_FILTERS.
- Counter wrap: window and tap address counters never exceed len-1; no wrap-around reads.

Optional Feature:
Macro CONV_PE_SATURATE_EN.
- Defined: if the accumulator exceeds 2^OUT_W-1, out_data = 2^OUT_W-1 (all ones).
- Undefined: truncation to the low OUT_W bits (wrap).
Identical results whenever the accumulator fits in OUT_W bits.

Test Plan:
- Defaults, reload=1, filters f0=[1,2,3,4], f1=[1,1,1,1], if=[1..8] (if_last on 8), stride=2 -> outputs (f,val): (0,30),(1,10),(0,50),(1,18),(0,70),(1,26); then done pulse; busy low.
- Follow-up start with reload=0, stride=0, if=[1..5] -> stride treated as 1; outputs (0,30),(1,10),(0,40),(1,14); filters reused without a flt handshake.
- if=[7,7,7] with if_last on word 3 -> no out_valid; done 1 cycle after LOAD_IF ends.
- out_ready held low 5 cycles on the first result -> out_data stable at 30 throughout; full sequence intact, no loss or duplication.
- OUT_W=16, all ifmap and filter words 255 -> out_data 63492 without the macro, 65535 with CONV_PE_SATURATE_EN.
- Assert rst during COMPUTE after the first result -> next cycle all outputs 0 and FSM IDLE; a new job with reload=1 produces correct results.
